// File: rtl/sipo_frame_ctrl.sv
// rtl/sipo_frame_ctrl.sv - framed serial-to-parallel capture controller
// Start bit, WIDTH data bits MSB-first, optional even parity, stop bit; valid/ready word output.
module sipo_frame_ctrl #(
   parameter int WIDTH     = 4,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_serial_in,
   input  logic             i_bit_valid,
   output logic [WIDTH-1:0] o_data_out,
   output logic             o_data_valid,
   input  logic             i_data_ready,
   output logic             o_busy,
   output logic             o_frame_err,
   output logic             o_parity_err,
   output logic             o_overrun
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DATA   = 2'd1;
   localparam logic [1:0] PARITY = 2'd2;
   localparam logic [1:0] STOP   = 2'd3;

   logic [1:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sh;
   logic             r_par_bad;
   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic             r_ferr;
   logic             r_perr;
   logic             r_ovr;

   logic w_stop_strobe;
   logic w_bad_stop;
   logic w_good;
   logic w_out_free;
   logic w_load;
   logic w_drop;
   logic w_accept;

   // The stop strobe judges the whole frame; errors win over overrun.
   assign w_stop_strobe = (r_state == STOP) & i_bit_valid;
   assign w_bad_stop    = ~i_serial_in;
   assign w_good        = ~w_bad_stop & ~r_par_bad;
   assign w_out_free    = ~r_valid | i_data_ready;
   assign w_load        = w_stop_strobe & w_good & w_out_free;
   assign w_drop        = w_stop_strobe & w_good & ~w_out_free;
   assign w_accept      = r_valid & i_data_ready;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_sh      <= '0;
         r_par_bad <= 1'b0;
      end else if (i_bit_valid) begin
         case (r_state)
            IDLE: begin
               if (!i_serial_in) begin
                  r_state   <= DATA;
                  r_cnt     <= '0;
                  r_par_bad <= 1'b0;
               end
            end
            DATA: begin
               r_sh <= {r_sh[WIDTH-2:0], i_serial_in};
               if (r_cnt == LAST_BIT) begin
                  r_state <= PARITY_EN ? PARITY : STOP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            PARITY: begin
               r_par_bad <= ^{r_sh, i_serial_in};
               r_state   <= STOP;
            end
            STOP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_perr  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_ferr <= w_stop_strobe & w_bad_stop;
         r_perr <= w_stop_strobe & r_par_bad;
         r_ovr  <= w_drop;
         if (w_load) begin
            r_data  <= r_sh;
            r_valid <= 1'b1;
         end else if (w_accept) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_data_out   = r_data;
   assign o_data_valid = r_valid;
   assign o_busy       = (r_state != IDLE);
   assign o_frame_err  = r_ferr;
   assign o_parity_err = r_perr;
   assign o_overrun    = r_ovr;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb/tb_sipo_frame_ctrl.sv - bench for sipo_frame_ctrl, parity and no-parity instances
module tb_sipo_frame_ctrl;

   logic       clk;
   logic       rst;
   logic       ser  [2];
   logic       bv   [2];
   logic       rdy  [2];
   logic [3:0] dout [2];
   logic       dv   [2];
   logic       busy [2];
   logic       fe   [2];
   logic       pe   [2];
   logic       ov   [2];

   int n_tests = 0;
   int n_fail  = 0;
   bit rand_rdy = 0;

   int       m_bits [2][12];
   int       m_n    [2];
   bit       m_busy [2];
   bit       m_dv   [2];
   bit [3:0] m_data [2];
   bit       m_fe   [2];
   bit       m_pe   [2];
   bit       m_ov   [2];

   bit       st_fe, st_pe, st_ov, st_dv, st_busy;
   bit [3:0] st_data;

   sipo_frame_ctrl #(.WIDTH(4), .PARITY_EN(1'b1)) u_dut_p1 (
      .i_clk(clk), .i_reset(rst), .i_serial_in(ser[0]), .i_bit_valid(bv[0]),
      .o_data_out(dout[0]), .o_data_valid(dv[0]), .i_data_ready(rdy[0]),
      .o_busy(busy[0]), .o_frame_err(fe[0]), .o_parity_err(pe[0]), .o_overrun(ov[0])
   );

   sipo_frame_ctrl #(.WIDTH(4), .PARITY_EN(1'b0)) u_dut_p0 (
      .i_clk(clk), .i_reset(rst), .i_serial_in(ser[1]), .i_bit_valid(bv[1]),
      .o_data_out(dout[1]), .o_data_valid(dv[1]), .i_data_ready(rdy[1]),
      .o_busy(busy[1]), .o_frame_err(fe[1]), .o_parity_err(pe[1]), .o_overrun(ov[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: collect bits after a start bit; judge once the frame length is reached.
   task automatic model_step(input int k, input bit r, input bit s, input bit v, input bit y);
      int par;
      int total;
      int ones;
      bit load;
      bit [3:0] word;
      par   = (k == 0) ? 1 : 0;
      total = 4 + par + 1;
      if (r) begin
         m_busy[k] = 0; m_n[k] = 0; m_dv[k] = 0; m_data[k] = 0;
         m_fe[k] = 0; m_pe[k] = 0; m_ov[k] = 0;
         return;
      end
      m_fe[k] = 0; m_pe[k] = 0; m_ov[k] = 0;
      load = 0;
      word = 0;
      if (v) begin
         if (!m_busy[k]) begin
            if (!s) begin
               m_busy[k] = 1;
               m_n[k] = 0;
            end
         end else begin
            m_bits[k][m_n[k]] = s ? 1 : 0;
            m_n[k]++;
            if (m_n[k] == total) begin
               m_busy[k] = 0;
               ones = 0;
               for (int i = 0; i < 4; i++) word = word * 2 + 4'(m_bits[k][i]);
               for (int i = 0; i < 4 + par; i++) ones += m_bits[k][i];
               m_pe[k] = (par == 1) && (ones % 2 == 1);
               m_fe[k] = (m_bits[k][total-1] == 0);
               if (!m_fe[k] && !m_pe[k]) begin
                  if (!m_dv[k] || y) load = 1;
                  else m_ov[k] = 1;
               end
            end
         end
      end
      if (load) begin
         m_data[k] = word;
         m_dv[k]   = 1;
      end else if (m_dv[k] && y) begin
         m_dv[k] = 0;
      end
   endtask

   task automatic cycle();
      bit sr;
      bit ss [2];
      bit sv [2];
      bit sy [2];
      if (rand_rdy) for (int k = 0; k < 2; k++) rdy[k] = 1'($urandom_range(0, 1));
      sr = rst;
      for (int k = 0; k < 2; k++) begin
         ss[k] = ser[k]; sv[k] = bv[k]; sy[k] = rdy[k];
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_step(k, sr, ss[k], sv[k], sy[k]);
      #1;
      for (int k = 0; k < 2; k++)
         check((k == 0) ? "cyc_par1" : "cyc_par0",
               {23'd0, busy[k], dv[k], dout[k], fe[k], pe[k], ov[k]},
               {23'd0, m_busy[k], m_dv[k], m_data[k], m_fe[k], m_pe[k], m_ov[k]});
   endtask

   task automatic send_frame(input int k, input bit [3:0] d, input bit par, input bit stp,
                             input int gap, input int stop_rdy);
      int  seq [7];
      int  n;
      bit  save;
      n = 0;
      seq[n++] = 0;
      for (int i = 3; i >= 0; i--) seq[n++] = d[i];
      if (k == 0) seq[n++] = par;
      seq[n++] = stp;
      save = rdy[k];
      for (int i = 0; i < n; i++) begin
         ser[k] = 1'(seq[i]);
         bv[k]  = 1'b1;
         if (i == n - 1 && stop_rdy >= 0) rdy[k] = 1'(stop_rdy);
         cycle();
         if (i == n - 1) begin
            st_fe = fe[k]; st_pe = pe[k]; st_ov = ov[k];
            st_dv = dv[k]; st_busy = busy[k]; st_data = dout[k];
            if (stop_rdy >= 0) rdy[k] = save;
         end
         bv[k]  = 1'b0;
         ser[k] = 1'b1;
         repeat (gap - 1) cycle();
      end
   endtask

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         ser[k] = 1'b1; bv[k] = 1'b0; rdy[k] = 1'b1; m_n[k] = 0;
      end
      repeat (3) cycle();
      check("rst_busy", {31'd0, busy[0]}, 0);
      check("rst_dv", {31'd0, dv[0]}, 0);
      check("rst_data", {28'd0, dout[0]}, 0);
      rst = 1'b0;
      cycle();

      // idle 1 strobes must be ignored
      ser[0] = 1'b1; bv[0] = 1'b1; cycle(); cycle(); bv[0] = 1'b0;
      check("idle_ones", {31'd0, busy[0]}, 0);

      send_frame(0, 4'b1011, 1'b1, 1'b1, 1, -1);
      check("t1_data", {28'd0, st_data}, 32'hB);
      check("t1_dv", {31'd0, st_dv}, 1);
      check("t1_errs", {29'd0, st_fe, st_pe, st_ov}, 0);

      send_frame(0, 4'b0110, 1'b1, 1'b1, 3, -1);
      check("t2_perr", {31'd0, st_pe}, 1);
      check("t2_dv", {31'd0, st_dv}, 0);
      check("t2_busy", {31'd0, st_busy}, 0);

      send_frame(0, 4'b1111, 1'b0, 1'b0, 1, -1);
      check("t3_ferr", {30'd0, st_fe, st_pe}, 32'h2);
      check("t3_data_held", {28'd0, st_data}, 32'hB);
      send_frame(0, 4'b0011, 1'b0, 1'b1, 3, -1);
      check("t3_next", {27'd0, st_dv, st_data}, 32'h13);

      rdy[0] = 1'b0;
      cycle(); cycle();
      send_frame(0, 4'b1010, 1'b0, 1'b1, 1, -1);
      send_frame(0, 4'b0101, 1'b0, 1'b1, 1, -1);
      check("t4_ovr", {31'd0, st_ov}, 1);
      check("t4_held", {27'd0, st_dv, st_data}, 32'h1A);
      rdy[0] = 1'b1;
      cycle();
      check("t4_accept", {31'd0, dv[0]}, 0);

      rdy[0] = 1'b0;
      send_frame(0, 4'b1010, 1'b0, 1'b1, 3, -1);
      send_frame(0, 4'b0101, 1'b0, 1'b1, 1, 1);
      check("t5_swap", {27'd0, st_dv, st_data}, 32'h15);
      check("t5_no_ovr", {31'd0, st_ov}, 0);

      ser[0] = 1'b0; bv[0] = 1'b1; cycle();
      ser[0] = 1'b1; cycle();
      ser[0] = 1'b1; cycle();
      bv[0] = 1'b0;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("t6_busy", {31'd0, busy[0]}, 0);
      check("t6_dv", {31'd0, dv[0]}, 0);
      send_frame(0, 4'b1100, 1'b0, 1'b1, 1, -1);
      check("t6_data", {27'd0, st_dv, st_data}, 32'h1C);

      rdy[1] = 1'b1;
      send_frame(1, 4'b1011, 1'b0, 1'b1, 3, -1);
      check("np_t1", {27'd0, st_dv, st_data}, 32'h1B);
      send_frame(1, 4'b1111, 1'b0, 1'b0, 1, -1);
      check("np_t3_ferr", {29'd0, st_fe, st_pe, st_ov}, 32'h4);
      send_frame(1, 4'b0011, 1'b0, 1'b1, 1, -1);
      check("np_t3_next", {27'd0, st_dv, st_data}, 32'h13);

      rand_rdy = 1;
      for (int f = 0; f < 120; f++) begin
         int       k;
         bit [3:0] d;
         bit       p;
         k = f % 2;
         d = 4'($urandom_range(0, 15));
         p = ^d;
         if ($urandom_range(0, 5) == 0) p = ~p;
         if ($urandom_range(0, 3) == 0) begin
            ser[k] = 1'b1; bv[k] = 1'b1; cycle(); bv[k] = 1'b0;
         end
         send_frame(k, d, p, ($urandom_range(0, 5) != 0), $urandom_range(1, 3), -1);
      end
      rand_rdy = 0;
      repeat (4) cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
